// File: rtl/dtimer16.sv
// 16-bit interval timer: an auto-reloading prescaler that steps an auto-reloading
// divider; tint pulses for one cycle each time the divider wraps back to its reload.
module dtimer16 (
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic        ena,
    input  logic [15:0] din,
    input  logic        wr_pre,
    input  logic        wr_div,
    output logic [15:0] pre_count,
    output logic [15:0] div_count,
    output logic        running,
    output logic        tint
);

    logic [15:0] pre_rld_q, pre_rld_d;
    logic [15:0] div_rld_q, div_rld_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic        tint_q, tint_d;
    logic        run;

    // A zero divider reload is the stop condition, so no separate enable bit exists.
    assign run = (div_rld_q != 16'd0);

    always_comb begin
        pre_rld_d = pre_rld_q;
        div_rld_d = div_rld_q;
        pre_cnt_d = pre_cnt_q;
        div_cnt_d = div_cnt_q;
        tint_d    = 1'b0;

        if (wr_pre || wr_div) begin
            // Writes win over any step on the same edge, so a colliding wrap is dropped.
            if (wr_pre) begin
                pre_rld_d = din;
                pre_cnt_d = din;
            end
            if (wr_div) begin
                div_rld_d = din;
                div_cnt_d = din;
            end
        end else if (ena && run) begin
            if (pre_cnt_q != 16'd0) begin
                pre_cnt_d = pre_cnt_q - 16'd1;
            end else begin
                pre_cnt_d = pre_rld_q;
                if (div_cnt_q != 16'd0) begin
                    div_cnt_d = div_cnt_q - 16'd1;
                end else begin
                    div_cnt_d = div_rld_q;
                    tint_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            pre_rld_q <= 16'd0;
            div_rld_q <= 16'd0;
            pre_cnt_q <= 16'd0;
            div_cnt_q <= 16'd0;
            tint_q    <= 1'b0;
        end else begin
            pre_rld_q <= pre_rld_d;
            div_rld_q <= div_rld_d;
            pre_cnt_q <= pre_cnt_d;
            div_cnt_q <= div_cnt_d;
            tint_q    <= tint_d;
        end
    end

    assign pre_count = pre_cnt_q;
    assign div_count = div_cnt_q;
    assign running   = run;
    assign tint      = tint_q;

endmodule

// File: tb/tb_dtimer16.sv
// Bench for dtimer16: the timer is modelled as one mixed-radix down-counter
// (position = div*(P+1)+pre) and checked every cycle, plus literal scenario checks.
module tb_dtimer16;

    logic        sys_clk = 1'b0;
    logic        resetl  = 1'b0;
    logic        ena     = 1'b0;
    logic [15:0] din     = 16'd0;
    logic        wr_pre  = 1'b0;
    logic        wr_div  = 1'b0;
    logic [15:0] pre_count, div_count;
    logic        running, tint;

    int vectors     = 0;
    int miscompares = 0;

    dtimer16 dut (
        .sys_clk  (sys_clk),
        .resetl   (resetl),
        .ena      (ena),
        .din      (din),
        .wr_pre   (wr_pre),
        .wr_div   (wr_div),
        .pre_count(pre_count),
        .div_count(div_count),
        .running  (running),
        .tint     (tint)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: P, D reloads and a single position counting down through (P+1)*(D+1) states.
    longint m_p = 0, m_d = 0, m_pos = 0;
    bit     m_tint  = 0;
    bit     m_valid = 0;

    always @(posedge sys_clk) begin
        longint pre, dv;
        if (!resetl) begin
            m_p = 0; m_d = 0; m_pos = 0; m_tint = 0; m_valid = 1;
        end else if (wr_pre || wr_div) begin
            pre = m_pos % (m_p + 1);
            dv  = m_pos / (m_p + 1);
            if (wr_pre) begin m_p = din; pre = din; end
            if (wr_div) begin m_d = din; dv = din; end
            m_pos  = dv * (m_p + 1) + pre;
            m_tint = 0;
        end else if (ena && m_d != 0) begin
            if (m_pos == 0) begin
                m_pos  = (m_p + 1) * (m_d + 1) - 1;
                m_tint = 1;
            end else begin
                m_pos  = m_pos - 1;
                m_tint = 0;
            end
        end else begin
            m_tint = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (m_valid) begin
            chk("model_pre_count", {16'd0, pre_count}, 32'(m_pos % (m_p + 1)));
            chk("model_div_count", {16'd0, div_count}, 32'(m_pos / (m_p + 1)));
            chk("model_running",   {31'd0, running},   {31'd0, (m_d != 0)});
            chk("model_tint",      {31'd0, tint},      {31'd0, m_tint});
        end
    end

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic write(input bit p, input bit d, input logic [15:0] v);
        wr_pre = p; wr_div = d; din = v;
        tick();
        wr_pre = 0; wr_div = 0;
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tint) pulses++;
        end
    endtask

    initial begin
        int pulses;
        int found;
        logic [15:0] seq [5];

        // Reset held over a write attempt
        resetl = 0; ena = 1; wr_div = 1; din = 16'h0005;
        tick(); tick();
        chk("reset_pre",  {16'd0, pre_count}, 32'd0);
        chk("reset_div",  {16'd0, div_count}, 32'd0);
        chk("reset_run",  {31'd0, running},   32'd0);
        chk("reset_tint", {31'd0, tint},      32'd0);
        wr_div = 0; ena = 0; resetl = 1;
        tick();

        // Basic divide: pre=0, div=3
        write(1, 0, 16'd0);
        write(0, 1, 16'd3);
        ena = 1;
        seq[0] = div_count;
        chk("basic_tint0", {31'd0, tint}, 32'd0);
        for (int i = 1; i < 5; i++) begin
            tick();
            seq[i] = div_count;
            chk("basic_tint", {31'd0, tint}, (i == 4) ? 32'd1 : 32'd0);
        end
        chk("basic_seq0", {16'd0, seq[0]}, 32'd3);
        chk("basic_seq1", {16'd0, seq[1]}, 32'd2);
        chk("basic_seq2", {16'd0, seq[2]}, 32'd1);
        chk("basic_seq3", {16'd0, seq[3]}, 32'd0);
        chk("basic_seq4", {16'd0, seq[4]}, 32'd3);

        // Prescale: pre=2, div=1 -> period 6
        ena = 0;
        write(1, 1, 16'd2);
        write(0, 1, 16'd1);
        chk("pre_seq0", {16'd0, pre_count}, 32'd2);
        ena = 1;
        tick(); chk("pre_seq1", {16'd0, pre_count}, 32'd1);
        tick(); chk("pre_seq2", {16'd0, pre_count}, 32'd0);
        tick(); chk("pre_seq3", {16'd0, pre_count}, 32'd2);
        ena = 0;
        write(1, 1, 16'd2);
        write(0, 1, 16'd1);
        ena = 1;
        count_pulses(60, pulses);
        chk("prescale_pulses_60", pulses, 32'd10);

        // Gating: div=3, ena alternating -> period 8
        ena = 0;
        write(1, 0, 16'd0);
        write(0, 1, 16'd3);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            ena = (i % 2 == 0);
            tick();
            if (tint) pulses++;
        end
        chk("gated_pulses_32", pulses, 32'd4);

        // Stop mid-count, then restart with div=2
        ena = 1;
        write(0, 1, 16'd3);
        tick();
        write(0, 1, 16'd0);
        chk("stop_running", {31'd0, running}, 32'd0);
        count_pulses(5, pulses);
        chk("stop_no_tint", pulses, 32'd0);
        chk("stop_frozen_div", {16'd0, div_count}, 32'd0);
        write(0, 1, 16'd2);
        found = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (tint) begin found = i; break; end
        end
        chk("restart_first_tint", found, 32'd3);

        // Collision: write on the cycle that would wrap
        ena = 1;
        write(0, 1, 16'd3);
        tick(); tick(); tick();
        chk("collide_setup_div", {16'd0, div_count}, 32'd0);
        write(1, 0, 16'd0);
        chk("collide_tint", {31'd0, tint}, 32'd0);
        chk("collide_div",  {16'd0, div_count}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            ena    = ($urandom % 4) != 0;
            wr_pre = ($urandom % 16) == 0;
            wr_div = ($urandom % 16) == 0;
            din    = (($urandom % 8) == 0) ? 16'($urandom) : 16'($urandom % 6);
            resetl = ($urandom % 300) != 0;
            tick();
        end
        resetl = 1; wr_pre = 0; wr_div = 0; ena = 0;
        tick();

        // Boundary: pre=0, div=0xFFFF -> first tint at enabled cycle 65536
        write(1, 0, 16'd0);
        write(0, 1, 16'hFFFF);
        ena = 1;
        found = 0;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (tint) begin found = i; break; end
        end
        chk("boundary_first_tint", found, 32'd65536);
        chk("boundary_div_reload", {16'd0, div_count}, 32'h0000FFFF);

        // Reset mid-count
        for (int i = 0; i < 100; i++) tick();
        resetl = 0;
        tick();
        chk("midreset_pre",  {16'd0, pre_count}, 32'd0);
        chk("midreset_div",  {16'd0, div_count}, 32'd0);
        chk("midreset_run",  {31'd0, running},   32'd0);
        chk("midreset_tint", {31'd0, tint},      32'd0);
        resetl = 1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
